// File: rtl/dendy_pkg.sv
// rtl/dendy_pkg.sv - shared types and constants for the sprite DMA path
package dendy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA = 16'h4014;
  localparam int          OAM_BYTES   = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA controller and CPU-side bus arbiter
module oam_dma_ctrl
  import dendy_pkg::*;
#(
  parameter logic [15:0] DMA_REG  = ADDR_OAMDMA,
  parameter int          OAM_SIZE = OAM_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_D,
  input  logic        cpu_R,
  input  logic        cpu_W,
  output logic        cpu_ce,
  output logic [15:0] A,
  output logic [7:0]  D,
  output logic        R,
  output logic        W,
  input  logic [7:0]  I,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we,
  output logic        busy
);

  localparam int CW = $clog2(OAM_SIZE);

  dma_state_t      state, state_d;
  logic [CW-1:0]   cnt;
  logic [7:0]      page;
  logic            parity;
  logic            trigger;
  logic            last_byte;

  assign trigger   = cpu_W && (cpu_A == DMA_REG);
  assign last_byte = (cnt == CW'(OAM_SIZE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      page     <= 8'h00;
      parity   <= 1'b0;
      oam_we   <= 1'b0;
      oam_addr <= 8'h00;
      oam_data <= 8'h00;
    end else begin
      // The OAM strobe is a single clock even when ce stays low afterwards.
      oam_we <= 1'b0;
      if (ce) begin
        state  <= state_d;
        busy   <= (state_d != IDLE);
        parity <= ~parity;
        if (state == IDLE && trigger) begin
          page <= cpu_D;
          cnt  <= '0;
        end
        if (state == WRITE) begin
          oam_data <= I;
          oam_addr <= 8'(cnt);
          oam_we   <= 1'b1;
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (trigger) state_d = HALT;
      // Parity here is the HALT tick's own; an even value means the next tick is odd.
      HALT:    state_d = parity ? READ : ALIGN;
      ALIGN:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = last_byte ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ce = ce;
    A      = cpu_A;
    D      = cpu_D;
    R      = cpu_R;
    W      = cpu_W;
    if (state != IDLE) begin
      cpu_ce = 1'b0;
      A      = {page, 8'(cnt)};
      D      = 8'h00;
      R      = (state == READ);
      W      = 1'b0;
    end
  end

endmodule
